// File: rtl/hex_digit_counter_pkg.sv
// Shared definitions for the hex digit counter: speed encodings and the
// period multiplier that turns a speed selection into a divider period.
package hex_counter_pkg;

    // Speed selection encodings driven on the speed input.
    typedef enum logic [1:0] {
        SPD_FULL    = 2'b00,
        SPD_1HZ     = 2'b01,
        SPD_HALF    = 2'b10,
        SPD_QUARTER = 2'b11
    } speed_t;

    // Number of one-second periods per digit step. SPD_FULL reports 1 here but
    // is special-cased by the divider to a period of one clock cycle.
    function automatic logic [2:0] mult(input logic [1:0] speed);
        logic [2:0] m;
        case (speed)
            SPD_FULL:    m = 3'd1;
            SPD_1HZ:     m = 3'd1;
            SPD_HALF:    m = 3'd2;
            SPD_QUARTER: m = 3'd4;
            default:     m = 3'd1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/hex_digit_counter_if.sv
// Control and status bundle of one hex digit counter.
//
// Signal semantics: there is no valid/ready handshake on this bundle. All
// inputs (enable, speed, load, load_value) are level signals sampled at every
// rising clock edge; digit and div_cnt are registered state, while tick and
// carry are combinational from that state and the current inputs and are
// meaningful for one cycle only.
interface hex_digit_counter_if #(
    parameter int DIV_W = 28
);
    logic             enable;
    logic [1:0]       speed;
    logic             load;
    logic [3:0]       load_value;
    logic [3:0]       digit;
    logic             tick;
    logic             carry;
    logic [DIV_W-1:0] div_cnt;   // divider state, exposed for observation

    // Producer of the control inputs (a bench or the parent design).
    modport master (
        output enable, speed, load, load_value,
        input  digit, tick, carry, div_cnt
    );

    // The counter itself.
    modport slave (
        input  enable, speed, load, load_value,
        output digit, tick, carry, div_cnt
    );
endinterface

// File: rtl/hex_digit_counter_rate_divider.sv
// Selectable-period rate divider. Produces a one-cycle tick every P(speed)
// enabled cycles. A restart or a change of speed reloads the down-counter so
// no partial period from the old setting survives.
module rate_divider
    import hex_counter_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int DIV_W         = $clog2(4 * TICKS_PER_SEC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       speed,
    input  logic             restart,
    output logic             tick,
    output logic [DIV_W-1:0] div_cnt
);

    logic [1:0]       speed_q;
    logic [DIV_W-1:0] cnt;
    logic             speed_change;

    // Period minus one for a given speed; computed two bits wider so that
    // 4*TICKS_PER_SEC never overflows before the subtraction.
    function automatic logic [DIV_W-1:0] reload_value(input logic [1:0] spd);
        logic [DIV_W+1:0] p;
        if (spd == SPD_FULL) begin
            p = (DIV_W + 2)'(1);
        end else begin
            p = (DIV_W + 2)'(mult(spd)) * (DIV_W + 2)'(TICKS_PER_SEC);
        end
        return DIV_W'(p - (DIV_W + 2)'(1));
    endfunction

    assign speed_change = (speed != speed_q);

    // Tick only in an enabled cycle with an expired count and a stable speed;
    // a restart suppresses it so the load cycle never also counts.
    always_comb begin
        tick = enable & ~restart & ~speed_change & (cnt == '0);
    end

    // Down-counter with priority reset > restart > speed change > enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            speed_q <= speed;
            cnt     <= reload_value(speed);
        end else if (restart) begin
            // Track speed here too so a speed change coinciding with a load
            // does not trigger a second reload on the following edge.
            speed_q <= speed;
            cnt     <= reload_value(speed);
        end else if (speed_change) begin
            speed_q <= speed;
            cnt     <= reload_value(speed);
        end else if (enable) begin
            if (cnt == '0) begin
                cnt <= reload_value(speed_q);
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    assign div_cnt = cnt;

endmodule

// File: rtl/hex_digit_counter.sv
// Rate-divided 4-bit hex counter feeding one 7-segment decoder. The digit
// advances on each divider tick; carry marks the F->0 wrap so several
// counters can be chained through their enable inputs.
module hex_digit_counter
    import hex_counter_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int DIV_W         = $clog2(4 * TICKS_PER_SEC)
) (
    input  logic               clock,
    input  logic               reset,
    hex_digit_counter_if.slave bus
);

    logic             tick;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       digit;

    rate_divider #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .DIV_W         (DIV_W)
    ) u_rate_divider (
        .clock   (clock),
        .reset   (reset),
        .enable  (bus.enable),
        .speed   (bus.speed),
        .restart (bus.load),
        .tick    (tick),
        .div_cnt (div_cnt)
    );

    // Digit register: reset clears, load overrides, otherwise step on tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit <= 4'h0;
        end else if (bus.load) begin
            digit <= bus.load_value;
        end else if (tick) begin
            digit <= digit + 4'd1;
        end
    end

    // Carry is the tick that wraps F back to 0.
    always_comb begin
        bus.carry = tick & (digit == 4'hF);
    end

    assign bus.digit   = digit;
    assign bus.tick    = tick;
    assign bus.div_cnt = div_cnt;

endmodule

// File: doc/hex_digit_counter.md
Name: hex_digit_counter

Overview:
- Upstream producer for the 7-segment path: a rate-divided 4-bit hex counter whose digit output drives the 4-bit input of the existing hex-to-7-segment decoder, one instance per HEX display.
- Contains a selectable-period rate divider (full speed, 1 Hz, 0.5 Hz, 0.25 Hz) plus a loadable, enable-gated 0..F counter.
- Exposes tick and carry so counters can be chained across displays.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per 1 Hz period. The bench overrides it with 4.
- DIV_W, derived as clog2(4*TICKS_PER_SEC), width of the divider down-counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  count enable; low freezes both divider and digit
- speed  in  2  00 = every cycle, 01 = 1 Hz, 10 = 0.5 Hz, 11 = 0.25 Hz
- load  in  1  synchronous parallel load of digit
- load_value  in  4  value loaded when load=1
- digit  out  4  current hex digit, registered; bit 3 is MSB. Connect to the decoder input in declared order so that digit[3] lands on the decoder's MSB.
- tick  out  1  one-cycle pulse in the cycle the digit advances; combinational from state
- carry  out  1  equals tick AND digit==4'hF (wrap F->0); chains to next digit's enable

Behaviour:
- Period P(speed): 00 -> 1; 01 -> TICKS_PER_SEC; 10 -> 2*TICKS_PER_SEC; 11 -> 4*TICKS_PER_SEC.
- State:
  - div_cnt [DIV_W-1:0], a down-counter
  - speed_q [1:0], a registered copy of speed
  - digit [3:0]
- Reset (reset=1 at an edge):
  - digit<=0, speed_q<=speed, div_cnt<=P(speed)-1.
  - tick and carry are 0 in the cycle after reset, unless P=1 and enable=1.
- Priority at each edge: reset > load > speed change > enable tick.
- load=1:
  - digit<=load_value and div_cnt<=P(speed)-1, regardless of enable.
  - No increment occurs and tick is forced 0 in that cycle.
- Speed change (speed!=speed_q, no reset or load):
  - speed_q<=speed and div_cnt<=P(speed)-1.
  - No tick that cycle; digit holds.
- enable=0: div_cnt, digit and speed_q hold (except for a speed change, which still reloads). tick=0, carry=0.
- enable=1, no load, no speed change:
  - div_cnt!=0: div_cnt decrements and tick=0.
  - div_cnt==0: tick=1, digit<=digit+1 (mod 16), div_cnt<=P-1.
- Latency: from reset release with enable=1, the first tick is in cycle P (cycles numbered 1.. after release). Ticks repeat every P cycles.
- speed=00: div_cnt stays 0, so tick=1 on every enabled cycle.
- Wrap: digit F->0 is silent. carry is high only in the tick cycle where digit==F.
- tick and carry are combinational: tick = enable & ~load & (speed==speed_q) & (div_cnt==0).
- Reset mid-count: state is discarded at the next edge and no partial period is retained.
- No X on any output after the first reset edge.

Decomposition:
- Shared package hex_counter_pkg:
  - speed encodings SPD_FULL=2'b00, SPD_1HZ=2'b01, SPD_HALF=2'b10, SPD_QUARTER=2'b11
  - period multiplier function mult(speed) returning 1, 1, 2, 4; SPD_FULL is special-cased to P=1
- One sub-module: rate_divider.
  - Inputs: clock, reset, enable, speed, restart.
  - Outputs: tick.
  - Holds div_cnt and speed_q.
- The top holds the digit register, load muxing and carry.

Test Plan:
- Full-speed wrap: TICKS=4, reset 2 cycles, enable=1, speed=00.
  - digit = 0,1,...,F,0 on consecutive cycles; tick=1 every cycle.
  - carry=1 only in the cycle where digit=F.
- 1 Hz timing: speed=01, enable=1 after reset.
  - tick pulses in cycles 4, 8, 12; digit steps 0->1->2->3 at those edges.
  - Check tick width is exactly 1 cycle.
- 0.25 Hz and speed change: run with speed=11 and see ticks every 16 cycles. Switch to 01 mid-count (div_cnt=9).
  - No tick in the switch cycle.
  - Next tick exactly 4 cycles after the switch edge.
- Enable freeze: speed=01, drop enable for 10 cycles at div_cnt=2, then restore.
  - digit and div_cnt are unchanged during the freeze; tick=0 throughout.
  - Next tick occurs 3 cycles after re-enable.
- Load priority: assert load=1, load_value=4'hA in a cycle where div_cnt==0 and enable=1.
  - tick=0 that cycle; digit=A next cycle.
  - Next tick at P cycles later, with digit becoming B.
  - Load F, tick once: digit 0 with carry=1 in the tick cycle.
- Reset mid-operation: assert reset with digit=7, div_cnt=1.
  - Next edge gives digit=0 and div_cnt=P-1.
  - No tick in the reset cycle; first tick after release is at cycle P.
